// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the approximate multiplier pipeline.
// Optional error statistics are enabled with APPROX_MUL_ERR_STATS_EN.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT  = 2'b00,
    MODE_OR     = 2'b01,
    MODE_ACARRY = 2'b10,
    MODE_ELIM   = 2'b11
  } mode_e;

  // Width of one compressed row-pair value V_p.
  function automatic int vp_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/approx_ha_pair.sv
// One row pair compressed by a configurable half-adder array into V_p.
// Purely combinational; instantiated once per row pair by approx_mul_pipe.
module approx_ha_pair
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         row_a,
  input  logic [WIDTH-1:0]         row_b,
  input  logic [2*(WIDTH-1)-1:0]   mode,
  output logic [vp_width(WIDTH)-1:0] vp
);

  localparam int VW = vp_width(WIDTH);

  logic a, b, s, c;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    a  = 1'b0;
    b  = 1'b0;
    s  = 1'b0;
    c  = 1'b0;
    vp = VW'(row_a[0]) + (VW'(row_b[WIDTH-1]) << WIDTH);
    for (int j = 1; j < WIDTH; j++) begin
      a = row_a[j];
      b = row_b[j-1];
      unique case (mode_e'(mode[2*(j-1) +: 2]))
        MODE_EXACT:  begin s = a ^ b; c = a & b; end
        MODE_OR:     begin s = a | b; c = 1'b0;  end
        MODE_ACARRY: begin s = 1'b0;  c = a;     end
        MODE_ELIM:   begin s = 1'b0;  c = 1'b0;  end
      endcase
      vp = vp + (VW'(s) << j) + (VW'(c) << (j + 1));
    end
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined approximate WIDTHxWIDTH multiplier with a per-pair mode table.
// Define APPROX_MUL_ERR_STATS_EN to add exact-product error statistics.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int STAT_W = 32,
  localparam int NPAIR  = WIDTH / 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_x,
  input  logic [WIDTH-1:0]           in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         out_prod,
  input  logic                       cfg_we,
  input  logic [$clog2(NPAIR)-1:0]   cfg_addr,
  input  logic [2*(WIDTH-1)-1:0]     cfg_data,
  input  logic                       stat_clr,
  output logic [31:0]                stat_ops,
  output logic [STAT_W-1:0]          stat_err
);

  localparam int CW = 2 * (WIDTH - 1);
  localparam int VW = vp_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic [CW-1:0]    cfg_q  [NPAIR];
  logic [CW-1:0]    snap_q [NPAIR];
  logic [WIDTH-1:0] x_q, y_q;
  logic [VW-1:0]    vp_d   [NPAIR];
  logic [VW-1:0]    vp_q   [NPAIR];
  logic [PW-1:0]    prod_d, prod_q;
  logic             s0_valid_q, s1_valid_q, s2_valid_q;

  // The whole pipe advances together; only a refused output holds it.
  assign in_ready  = !(s2_valid_q && !out_ready);
  assign out_valid = s2_valid_q;
  assign out_prod  = prod_q;

  for (genvar gp = 0; gp < NPAIR; gp++) begin : g_pair
    approx_ha_pair #(.WIDTH(WIDTH)) u_pair (
      .row_a (y_q & {WIDTH{x_q[2*gp]}}),
      .row_b (y_q & {WIDTH{x_q[2*gp+1]}}),
      .mode  (snap_q[gp]),
      .vp    (vp_d[gp])
    );
  end

  always_comb begin
    prod_d = '0;
    for (int p = 0; p < NPAIR; p++) begin
      prod_d = prod_d + (PW'(vp_q[p]) << (2 * p));
    end
  end

  // Control state and the mode table; all-zero table means every cell exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      for (int p = 0; p < NPAIR; p++) begin
        cfg_q[p] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (cfg_we && int'(cfg_addr) < NPAIR) begin
        cfg_q[cfg_addr] <= cfg_data;
      end
      if (in_ready) begin
        s0_valid_q <= in_valid;
        s1_valid_q <= s0_valid_q;
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          prod_q <= prod_d;
        end
      end
    end
  end

  // NOTE: datapath registers are left unreset; the stage valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      if (in_valid) begin
        x_q    <= in_x;
        y_q    <= in_y;
        snap_q <= cfg_q;
      end
      if (s0_valid_q) begin
        vp_q <= vp_d;
      end
    end
  end

`ifdef APPROX_MUL_ERR_STATS_EN
  localparam int SW = ((STAT_W > PW) ? STAT_W : PW) + 1;

  logic [PW-1:0]     exact1_q, exact2_q, diff;
  logic [SW-1:0]     err_sum;
  logic [STAT_W-1:0] err_d, err_q;
  logic [31:0]       ops_q;

  always_ff @(posedge clk) begin
    if (in_ready) begin
      if (s0_valid_q) begin
        exact1_q <= PW'(x_q) * PW'(y_q);
      end
      if (s1_valid_q) begin
        exact2_q <= exact1_q;
      end
    end
  end

  always_comb begin
    diff    = (exact2_q >= prod_q) ? (exact2_q - prod_q) : (prod_q - exact2_q);
    err_sum = SW'(err_q) + SW'(diff);
    err_d   = (err_sum > SW'({STAT_W{1'b1}})) ? '1 : err_sum[STAT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      ops_q <= '0;
      err_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      ops_q <= ops_q + 32'd1;
      err_q <= err_d;
    end
  end

  assign stat_ops = ops_q;
  assign stat_err = err_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign stat_ops        = '0;
  assign stat_err        = '0;
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe: random and directed operands against a
// mode-rule reference model; stats checks follow APPROX_MUL_ERR_STATS_EN.
module tb_approx_mul_pipe;

  localparam int WIDTH  = 8;
  localparam int NPAIR  = 4;
  localparam int CW     = 14;
  localparam int STAT_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_x = '0;
  logic [WIDTH-1:0]  in_y = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       out_prod;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = '0;
  logic [CW-1:0]     cfg_data = '0;
  logic              stat_clr = 1'b0;
  logic [31:0]       stat_ops;
  logic [STAT_W-1:0] stat_err;

  always #5 clk = ~clk;

  approx_mul_pipe #(.WIDTH(WIDTH), .STAT_W(STAT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .stat_clr  (stat_clr),
    .stat_ops  (stat_ops),
    .stat_err  (stat_err)
  );

  typedef struct {
    logic [15:0] prod;
    logic [15:0] exact;
  } exp_t;

  exp_t                      sb_q[$];
  logic [NPAIR-1:0][CW-1:0]  cfg_m = '0;
  int                        n_checks = 0;
  int                        n_fail = 0;
  bit                        rdy_rand = 1'b0;
  longint unsigned           ops_m = 0;
  longint unsigned           err_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: evaluate each cell of each row pair from the mode rules.
  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y,
                                           input logic [NPAIR-1:0][CW-1:0] cfg);
    int unsigned total = 0;
    for (int p = 0; p < NPAIR; p++) begin
      int unsigned ra = x[2*p]   ? int'(y) : 0;
      int unsigned rb = x[2*p+1] ? int'(y) : 0;
      int unsigned v  = ra & 1;
      for (int j = 1; j < WIDTH; j++) begin
        int unsigned a = (ra >> j) & 1;
        int unsigned b = (rb >> (j - 1)) & 1;
        case (cfg[p][2*(j-1) +: 2])
          2'b00:   v += ((a ^ b) << j) + ((a & b) << (j + 1));
          2'b01:   v += (a | b) << j;
          2'b10:   v += a << (j + 1);
          default: v += 0;
        endcase
      end
      v += ((rb >> (WIDTH - 1)) & 1) << WIDTH;
      total += v << (2 * p);
    end
    return 16'(total);
  endfunction

  task automatic cycle(input bit v, input logic [7:0] x, input logic [7:0] y, input bit we,
                       input logic [1:0] addr, input logic [CW-1:0] data, output bit acc);
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_data  = data;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (rst) begin
      cfg_m = '0;
    end else begin
      // The operand is modelled with the table as it stood before this cycle's write.
      if (acc) sb_q.push_back('{ref_prod(x, y, cfg_m), 16'(x) * 16'(y)});
      if (we && int'(addr) < NPAIR) cfg_m[addr] = data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle(1'b0, '0, '0, 1'b0, '0, '0, acc);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [CW-1:0] data);
    bit acc;
    cycle(1'b0, '0, '0, 1'b1, addr, data, acc);
  endtask

  // Accept one operand into an empty pipe, measure latency and check the product.
  task automatic directed(input logic [7:0] x, input logic [7:0] y, input bit we,
                          input logic [CW-1:0] data, input logic [15:0] exp);
    int k;
    bit acc;
    cycle(1'b1, x, y, we, 2'd0, data, acc);
    check("dir_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 10) begin
      k++;
      @(negedge clk);
    end
    check("dir_latency", 64'(k), 64'd3);
    check("dir_prod", 64'(out_prod), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  exp_t            mon_e;
  longint unsigned mon_diff;
  bit              prev_stall = 1'b0;
  logic [15:0]     held_prod;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
      ops_m      = 0;
      err_m      = 0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_prod", 64'(out_prod), 64'(held_prod));
      end
`ifdef APPROX_MUL_ERR_STATS_EN
      check("stat_ops", 64'(stat_ops), ops_m);
      check("stat_err", 64'(stat_err), err_m);
`else
      check("stat_ops_tied", 64'(stat_ops), 64'd0);
      check("stat_err_tied", 64'(stat_err), 64'd0);
`endif
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d expected no output at %0t", out_prod, $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("prod", 64'(out_prod), 64'(mon_e.prod));
          mon_diff = (mon_e.exact >= mon_e.prod) ? 64'(mon_e.exact - mon_e.prod)
                                                 : 64'(mon_e.prod - mon_e.exact);
          ops_m = (ops_m + 1) & 64'hFFFF_FFFF;
          err_m = err_m + mon_diff;
          if (err_m > ((64'd1 << STAT_W) - 1)) err_m = (64'd1 << STAT_W) - 1;
        end
      end
      if (stat_clr) begin
        ops_m = 0;
        err_m = 0;
      end
      prev_stall = out_valid && !out_ready;
      held_prod  = out_prod;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int n;
    int guard;

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_prod", 64'(out_prod), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stat_ops", 64'(stat_ops), 64'd0);
    check("rst_stat_err", 64'(stat_err), 64'd0);

    // Exact table after reset.
    directed(8'd255, 8'd255, 1'b0, '0, 16'd65025);
    directed(8'd13, 8'd11, 1'b0, '0, 16'd143);

    // Pair 0 all OR, then all eliminate.
    cfg_write(2'd0, 14'h1555);
    directed(8'd3, 8'd3, 1'b0, '0, 16'd7);
    cfg_write(2'd0, 14'h3FFF);
    directed(8'd3, 8'd3, 1'b0, '0, 16'd1);

    // Cell 1 A-carry only: a=0 drops b, leaving just rowa[0].
    cfg_write(2'd0, 14'h0002);
    directed(8'd3, 8'd1, 1'b0, '0, 16'd1);

    // Write in the accept cycle: this operand still sees cell1 A-carry (9), the next sees eliminate (1).
    directed(8'd3, 8'd3, 1'b1, 14'h3FFF, 16'd9);
    directed(8'd3, 8'd3, 1'b0, '0, 16'd1);

    // Writes while three operations are in flight.
    cycle(1'b1, 8'd3, 8'd3, 1'b0, 2'd0, '0, acc);
    cycle(1'b1, 8'd3, 8'd3, 1'b1, 2'd0, 14'h1555, acc);
    cycle(1'b1, 8'd3, 8'd3, 1'b1, 2'd0, 14'h0000, acc);
    cycle(1'b1, 8'd3, 8'd3, 1'b0, 2'd0, '0, acc);
    idle(6);
    check("inflight_drained", 64'(sb_q.size()), 64'd0);

    // Random operands and random table writes at full throughput.
    for (int i = 0; i < 11000; i++) begin
      cycle(1'($urandom_range(0, 9) != 0), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 15) == 0), 2'($urandom), 14'($urandom), acc);
    end
    idle(6);
    check("random_drained", 64'(sb_q.size()), 64'd0);

    // Backpressure: 20 operations with a random consumer.
    rdy_rand = 1'b1;
    n = 0;
    guard = 0;
    while (n < 20 && guard < 1000) begin
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, '0, '0, acc);
      if (acc) n++;
      guard++;
    end
    check("bp_accepted", 64'(n), 64'd20);
    rdy_rand = 1'b0;
    idle(8);
    check("bp_drained", 64'(sb_q.size()), 64'd0);

    // Reset mid-stream discards in-flight operations.
    cycle(1'b1, 8'd200, 8'd77, 1'b0, '0, '0, acc);
    cycle(1'b1, 8'd91, 8'd45, 1'b0, '0, '0, acc);
    cycle(1'b1, 8'd17, 8'd230, 1'b0, '0, '0, acc);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    idle(6);
    check("flush_no_output", 64'(sb_q.size()), 64'd0);
    directed(8'd13, 8'd11, 1'b0, '0, 16'd143);

`ifdef APPROX_MUL_ERR_STATS_EN
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    cfg_write(2'd0, 14'h1555);
    repeat (4) cycle(1'b1, 8'd3, 8'd3, 1'b0, '0, '0, acc);
    idle(6);
    check("stats_ops4", 64'(stat_ops), 64'd4);
    check("stats_err8", 64'(stat_err), 64'd8);
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    check("stats_clr_ops", 64'(stat_ops), 64'd0);
    check("stats_clr_err", 64'(stat_err), 64'd0);
`endif

    idle(4);
    check("final_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
